instruction_fetch_unit: RTL and testbench

//  Fetch-side requester for the word-addressed instruction memory. Owns the PC,

---
 rtl/instruction_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and IF/ID register for the word-addressed instruction memory
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 32,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    // first byte address past the populated memory
    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic [31:0] pc_plus4_next;
    logic        valid_next;
    logic [15:0] stall_count_next;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        pc_in_range;
    logic        next_in_range;
    logic        target_in_range;

    // redirect targets are always word aligned
    assign target          = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus4        = pc + 32'd4;
    assign pc_in_range     = (pc < PC_LIMIT);
    assign next_in_range   = (pc_plus4 < PC_LIMIT);
    assign target_in_range = (target < PC_LIMIT);

    assign instr_addr = pc;
    assign halted     = (state == HALT);

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // next-state and next datapath values; priority redirect > out-of-range pc > stall > fetch
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instr_next       = if_id_instr;
        pc_plus4_next    = if_id_pc_plus4;
        valid_next       = if_id_valid;
        stall_count_next = stall_count;
        case (state)
            FETCH: begin
                if (redirect) begin
                    pc_next    = target;
                    instr_next = NOP_WORD;
                    valid_next = 1'b0;
                end else if (!pc_in_range) begin
                    // reached only through reset or a redirect target; nothing valid to fetch
                    instr_next = NOP_WORD;
                    valid_next = 1'b0;
                    state_next = HALT;
                end else if (stall) begin
                    if (stall_count != 16'hFFFF) begin
                        stall_count_next = stall_count + 16'd1;
                    end
                end else begin
                    instr_next    = instr_rdata;
                    pc_plus4_next = pc_plus4;
                    valid_next    = 1'b1;
                    // the last word is still captured; pc parks on it
                    if (next_in_range) begin
                        pc_next = pc_plus4;
                    end else begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                instr_next = NOP_WORD;
                valid_next = 1'b0;
                if (redirect) begin
                    pc_next = target;
                    if (target_in_range) begin
                        state_next = FETCH;
                    end
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // pc, IF/ID register and stall counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            stall_count    <= 16'd0;
        end else begin
            pc             <= pc_next;
            if_id_instr    <= instr_next;
            if_id_pc_plus4 <= pc_plus4_next;
            if_id_valid    <= valid_next;
            stall_count    <= stall_count_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    logic [31:0] addr_a, rdata_a, instr_a, p4_a;
    logic        valid_a, halted_a;
    logic [15:0] cnt_a;
    logic [31:0] addr_b, rdata_b, instr_b, p4_b;
    logic        valid_b, halted_b;
    logic [15:0] cnt_b;

    logic [31:0] mem [0:31];

    assign rdata_a = (addr_a[31:7] == 25'd0) ? mem[addr_a[6:2]] : (32'hBAD0_0000 ^ addr_a);
    assign rdata_b = (addr_b[31:7] == 25'd0) ? mem[addr_b[6:2]] : (32'hBAD0_0000 ^ addr_b);

    instruction_fetch_unit dut_a (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_addr(addr_a), .instr_rdata(rdata_a),
        .if_id_instr(instr_a), .if_id_pc_plus4(p4_a), .if_id_valid(valid_a),
        .halted(halted_a), .stall_count(cnt_a)
    );

    instruction_fetch_unit #(.IMEM_WORDS(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_addr(addr_b), .instr_rdata(rdata_b),
        .if_id_instr(instr_b), .if_id_pc_plus4(p4_b), .if_id_valid(valid_b),
        .halted(halted_b), .stall_count(cnt_b)
    );

    // reference model, index 0 = 32-word memory, index 1 = 4-word memory
    int unsigned lim [2] = '{128, 16};
    logic [31:0] m_pc [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_p4 [2];
    logic        m_valid [2];
    logic        m_halt [2];
    int unsigned m_cnt [2];

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] sat_cnt(input int unsigned c);
        return (c > 65535) ? 32'd65535 : c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'd0; m_instr[i] = NOP; m_p4[i] = 32'd0;
            m_valid[i] = 1'b0; m_halt[i] = 1'b0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge(input int i, input logic st, input logic rd, input logic [31:0] rpc);
        logic [31:0] t;
        t = {rpc[31:2], 2'b00};
        if (m_halt[i]) begin
            m_instr[i] = NOP; m_valid[i] = 1'b0;
            if (rd) begin
                m_pc[i] = t;
                m_halt[i] = !(t < lim[i]);
            end
        end else if (rd) begin
            m_pc[i] = t; m_instr[i] = NOP; m_valid[i] = 1'b0;
        end else if (!(m_pc[i] < lim[i])) begin
            m_instr[i] = NOP; m_valid[i] = 1'b0; m_halt[i] = 1'b1;
        end else if (st) begin
            m_cnt[i]++;
        end else begin
            m_instr[i] = mem[m_pc[i] / 4];
            m_p4[i] = m_pc[i] + 4;
            m_valid[i] = 1'b1;
            if (m_pc[i] + 4 < lim[i]) m_pc[i] = m_pc[i] + 4;
            else m_halt[i] = 1'b1;
        end
    endtask

    task automatic check_all();
        check("a.instr_addr", addr_a, m_pc[0]);
        check("a.if_id_instr", instr_a, m_instr[0]);
        check("a.if_id_pc_plus4", p4_a, m_p4[0]);
        check("a.if_id_valid", {31'd0, valid_a}, {31'd0, m_valid[0]});
        check("a.halted", {31'd0, halted_a}, {31'd0, m_halt[0]});
        check("a.stall_count", {16'd0, cnt_a}, sat_cnt(m_cnt[0]));
        check("b.instr_addr", addr_b, m_pc[1]);
        check("b.if_id_instr", instr_b, m_instr[1]);
        check("b.if_id_pc_plus4", p4_b, m_p4[1]);
        check("b.if_id_valid", {31'd0, valid_b}, {31'd0, m_valid[1]});
        check("b.halted", {31'd0, halted_b}, {31'd0, m_halt[1]});
        check("b.stall_count", {16'd0, cnt_b}, sat_cnt(m_cnt[1]));
    endtask

    // called at posedge+1; drives one cycle of inputs and checks after the edge
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input bit chk = 1'b1);
        stall = st; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        model_edge(0, st, rd, rpc);
        model_edge(1, st, rd, rpc);
        #1;
        if (chk) check_all();
    endtask

    // asynchronous assertion between edges, held over an edge, released away from the edge
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        reset_n = 1'b1;
        #1;
        check("rel.instr_addr", addr_a, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = 32'h8D09_0000;
        mem[1] = 32'h2129_0001;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // straight-line fetch
        step(1'b0, 1'b0, 32'd0);
        check("t2.e1.instr", instr_a, 32'h8D09_0000);
        check("t2.e1.pc_plus4", p4_a, 32'd4);
        check("t2.e1.valid", {31'd0, valid_a}, 32'd1);
        // load-use stall for two cycles
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("t3.instr", instr_a, 32'h8D09_0000);
        check("t3.addr", addr_a, 32'd4);
        check("t3.stall_count", {16'd0, cnt_a}, 32'd2);
        step(1'b0, 1'b0, 32'd0);
        check("t2.e2.instr", instr_a, 32'h2129_0001);
        check("t2.e2.pc_plus4", p4_a, 32'd8);
        check("t2.e2.addr", addr_a, 32'd8);
        // redirect beats stall, unaligned target
        step(1'b1, 1'b1, 32'h13);
        check("t4.addr", addr_a, 32'h10);
        check("t4.instr", instr_a, NOP);
        check("t4.valid", {31'd0, valid_a}, 32'd0);
        check("t4.stall_count", {16'd0, cnt_a}, 32'd2);
        // out-of-range redirect target
        step(1'b0, 1'b1, 32'h80);
        step(1'b0, 1'b0, 32'd0);
        check("t6.halted", {31'd0, halted_a}, 32'd1);
        check("t6.valid", {31'd0, valid_a}, 32'd0);
        check("t6.addr", addr_a, 32'h80);

        // end of a 4-word memory
        do_reset();
        repeat (4) step(1'b0, 1'b0, 32'd0);
        check("t5.last.instr", instr_b, mem[3]);
        check("t5.last.valid", {31'd0, valid_b}, 32'd1);
        check("t5.last.addr", addr_b, 32'hC);
        step(1'b1, 1'b0, 32'd0);
        check("t5.halt.halted", {31'd0, halted_b}, 32'd1);
        check("t5.halt.valid", {31'd0, valid_b}, 32'd0);
        check("t5.halt.addr", addr_b, 32'hC);
        step(1'b0, 1'b1, 32'd0);
        check("t5.resume.halted", {31'd0, halted_b}, 32'd0);
        check("t5.resume.addr", addr_b, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("t5.resume.instr", instr_b, mem[0]);

        // randomized traffic with occasional mid-run reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, 32'($urandom_range(0, 159)));
        end

        // stall counter saturation
        do_reset();
        repeat (65540) step(1'b1, 1'b0, 32'd0, 1'b0);
        check_all();
        check("sat.stall_count", {16'd0, cnt_a}, 32'h0000_FFFF);
        step(1'b0, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
